// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Contents:
//   tts_state_t : sweep FSM states
//   SettleW     : width of the per-pattern settle counter
//   npat()      : number of input patterns for a given input count
package tts_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StApply  = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } tts_state_t;

    // Settle delays range over 0..15.
    localparam int unsigned SettleW = 4;

    function automatic int unsigned npat(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/tts_settle_timer.sv
// Loadable down-counter with a zero flag. It is reloaded at the start of every
// pattern and counts down to zero, where it holds until the next load.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   load_i     : load load_val_i this cycle (takes priority over counting)
//   load_val_i : value to load
//   zero_o     : counter is at zero
module tts_settle_timer
    import tts_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [SettleW-1:0] load_val_i,
    output logic               zero_o
);

    logic [SettleW-1:0] cnt_q;
    logic [SettleW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine for a combinational block with N_IN inputs.
// On start it drives patterns 0..2^N_IN-1 in order on stim, waits SETTLE+1
// cycles per pattern, samples f_in, and scores it against EXPECT.
// Ports:
//   clk             : rising-edge clock
//   rst             : asynchronous active-high reset; aborts any sweep
//   start           : begin a sweep (honoured only in idle/done)
//   stim            : pattern driven to the block under test
//   f_in            : response of the block under test
//   busy            : sweep in progress
//   done            : one-cycle pulse at the end of a sweep
//   pass            : last completed sweep had no mismatches
//   err_count       : mismatch count of the current or last sweep
//   first_err       : lowest failing pattern
//   first_err_valid : first_err holds a real index
// All outputs come straight from registers.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int unsigned              N_IN   = 4,
    parameter int unsigned              SETTLE = 1,
    parameter logic [npat(N_IN)-1:0]    EXPECT = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            f_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err,
    output logic            first_err_valid
);

    localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE);

    tts_state_t state_q, state_d;

    // The pattern register is stim itself, so stim only moves when p moves.
    logic [N_IN-1:0] p_q, p_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] first_q, first_d;
    logic            fvalid_q, fvalid_d;

    logic            timer_load;
    logic            timer_zero;
    logic            mismatch;
    logic            last_pat;

    tts_settle_timer u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (SettleLoad),
        .zero_o     (timer_zero)
    );

    assign mismatch = (f_in != EXPECT[p_q]);
    // Terminal-value detect: the counter never wraps back to 0 mid-sweep.
    assign last_pat = (p_q == '1);

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        first_d    = first_q;
        fvalid_d   = fvalid_q;
        timer_load = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StApply;
                    p_d        = '0;
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    err_d      = '0;
                    first_d    = '0;
                    fvalid_d   = 1'b0;
                    timer_load = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end

            StApply: begin
                if (timer_zero) begin
                    state_d = StSample;
                end
            end

            StSample: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!fvalid_q) begin
                        first_d  = p_q;
                        fvalid_d = 1'b1;
                    end
                end
                if (last_pat) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // Uses err_d so the final sample is included.
                    pass_d  = (err_d == '0);
                end else begin
                    state_d    = StApply;
                    p_d        = p_q + 1'b1;
                    timer_load = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            first_q  <= '0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            first_q  <= first_d;
            fvalid_q <= fvalid_d;
        end
    end

    assign stim            = p_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err       = first_q;
    assign first_err_valid = fvalid_q;

endmodule
